// File: rtl/bitonic_merge_sched.sv
// bitonic_merge_sched: round-robin, credit-gated issue into a fixed-latency merge network with tag tracking and an output FIFO
module bitonic_merge_sched #(
  parameter int N           = 16,
  parameter int LOG_N       = 4,
  parameter int INPUT_WIDTH = 4,
  parameter int NUM_REQ     = 4,
  parameter int LOG_REQ     = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int LOG_FIFO    = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*N*INPUT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [N*INPUT_WIDTH-1:0]         merge_in,
  input  logic [N*INPUT_WIDTH-1:0]         merge_out,
  output logic                             out_valid,
  output logic [N*INPUT_WIDTH-1:0]         out_data,
  output logic [LOG_REQ-1:0]               out_id,
  input  logic                             out_ready,
  output logic                             busy
);
  localparam int LAT = LOG_N + 1;
  localparam int W   = N * INPUT_WIDTH;
  localparam int IW  = $clog2(LAT + 1);
  localparam int CW  = LOG_FIFO + 2;
  logic [LOG_REQ-1:0] rr_ptr;
  logic [LOG_REQ-1:0] winner;
  logic               grant;
  logic               issue_ok;
  logic [LAT-1:0]     tag_v;
  logic [LOG_REQ-1:0] tag_id [LAT];
  logic [IW-1:0]      inflight;
  logic [LOG_FIFO:0]  fifo_count;
  logic [LOG_FIFO-1:0] rd_ptr;
  logic [LOG_FIFO-1:0] wr_ptr;
  logic [LOG_FIFO-1:0] rd_nxt;
  logic [W+LOG_REQ-1:0] mem [FIFO_DEPTH];
  logic               wr;
  logic               pop;
  // a pop in the same cycle deliberately earns no credit; in-flight plus stored results never exceed the FIFO
  assign issue_ok  = !reset && (CW'(inflight) + CW'(fifo_count) < CW'(FIFO_DEPTH));
  assign wr        = tag_v[LAT-1];
  assign out_valid = fifo_count != '0;
  assign pop       = out_valid && out_ready;
  assign rd_nxt    = rd_ptr + LOG_FIFO'(pop);
  assign busy      = inflight != '0 || fifo_count != '0;
  assign req_ready = grant ? NUM_REQ'(1) << winner : '0;
  assign merge_in  = grant ? req_data[winner*W +: W] : '0;
  // round-robin search starting just after the last winner
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant && issue_ok && req_valid[rr_ptr + LOG_REQ'(k)]) begin
        grant  = 1'b1;
        winner = rr_ptr + LOG_REQ'(k);
      end
    end
  end
  // tag pipeline mirrors the network latency; inflight counts tags not yet written to the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_v    <= '0;
      rr_ptr   <= LOG_REQ'(NUM_REQ - 1);
      inflight <= '0;
      for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_v     <= {tag_v[LAT-2:0], grant};
      tag_id[0] <= winner;
      for (int k = 1; k < LAT; k++) tag_id[k] <= tag_id[k-1];
      if (grant) rr_ptr <= winner;
      inflight <= inflight + IW'(grant) - IW'(wr);
    end
  end
  // FIFO storage; contents need no reset because pointers and count gate every read
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {merge_out, tag_id[LAT-1]};
  end
  // FIFO pointers and registered head; a write landing at the new head bypasses the storage
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      out_data   <= '0;
      out_id     <= '0;
    end else begin
      wr_ptr     <= wr_ptr + LOG_FIFO'(wr);
      rd_ptr     <= rd_nxt;
      fifo_count <= fifo_count + (LOG_FIFO+1)'(wr) - (LOG_FIFO+1)'(pop);
      {out_data, out_id} <= (wr && wr_ptr == rd_nxt) ? {merge_out, tag_id[LAT-1]} : mem[rd_nxt];
    end
  end
endmodule

// File: tb/tb_bitonic_merge_sched.sv
// tb_bitonic_merge_sched: directed tests with a behavioural merge network and an in-order result scoreboard
module tb_bitonic_merge_sched;
  localparam int N = 16, LOG_N = 4, EW = 4, NR = 4, LR = 2, FD = 8, LF = 3;
  localparam int LAT = LOG_N + 1, W = N * EW;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic [W-1:0] merge_in, merge_out, out_data;
  logic out_valid, out_ready = 1'b0, busy;
  logic [LR-1:0] out_id;
  logic [W-1:0] pipe [LAT];
  logic [LR+W-1:0] sb [$];
  logic [LR+W-1:0] sb_e;
  int checks = 0, failures = 0, mon_id;
  bit ovf = 1'b0;
  always #5 clk = ~clk;
  bitonic_merge_sched #(.N(N), .LOG_N(LOG_N), .INPUT_WIDTH(EW), .NUM_REQ(NR), .LOG_REQ(LR),
                        .FIFO_DEPTH(FD), .LOG_FIFO(LF)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .merge_in(merge_in), .merge_out(merge_out), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .out_ready(out_ready), .busy(busy));
  function automatic logic [W-1:0] sort_seq(input logic [W-1:0] s);
    logic [EW-1:0] e [N];
    logic [EW-1:0] t;
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) e[i] = s[i*EW +: EW];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (e[j] > e[j+1]) begin t = e[j]; e[j] = e[j+1]; e[j+1] = t; end
    r = '0;
    for (int i = 0; i < N; i++) r[i*EW +: EW] = e[i];
    return r;
  endfunction
  // merge network model: input register plus LOG_N stages, ascending output
  always @(posedge clk) begin
    if (reset) for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    else begin
      pipe[0] <= merge_in;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign merge_out = sort_seq(pipe[LAT-1]);
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // scoreboard: every grant must come out once, in order, sorted
  always @(negedge clk) begin
    if (reset) sb.delete();
    else begin
      if (dut.tag_v[LAT-1] && dut.fifo_count == (LF+1)'(FD)) ovf = 1'b1;
      if (req_ready != '0) begin
        mon_id = 0;
        for (int i = 0; i < NR; i++) if (req_ready[i]) mon_id = i;
        chk("onehot", W'($countones(req_ready)), W'(1));
        chk("merge_in", merge_in, req_data[mon_id*W +: W]);
        sb.push_back({LR'(mon_id), sort_seq(req_data[mon_id*W +: W])});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("pop_unexpected", W'(1), W'(0));
        else begin
          sb_e = sb.pop_front();
          chk("sb_id", W'(out_id), W'(sb_e[W +: LR]));
          chk("sb_data", out_data, sb_e[W-1:0]);
        end
      end
    end
  end
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    nxt();
    reset = 1'b1;
    req_valid = '0;
    nxt();
    reset = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    req_valid = '0;
    out_ready = 1'b1;
    @(negedge clk);
    while (busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", W'(busy), W'(0));
    chk("sb_empty", W'(sb.size()), W'(0));
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    logic [NR-1:0] t4_v [6];
    logic [NR-1:0] t4_g [6];
    t4_v = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1011, 4'b1011};
    t4_g = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0001, 4'b0010};
    req_data = {64'h1F2E3D4C5B6A7988, 64'h89ABCDEF76543210, 64'h0011223344556677, 64'hFEDCBA9876543210};
    do_reset();
    @(negedge clk);
    chk("rst_ready", W'(req_ready), W'(0));
    chk("rst_merge_in", merge_in, W'(0));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_data", out_data, W'(0));
    chk("rst_out_id", W'(out_id), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    nxt();
    out_ready = 1'b1;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t1_grant", W'(req_ready), W'(4'b0100));
    chk("t1_merge_in", merge_in, 64'h89ABCDEF76543210);
    for (int c = 1; c <= 7; c++) begin
      nxt();
      req_valid = '0;
      @(negedge clk);
      chk("t1_out_valid", W'(out_valid), W'(c == 6));
      if (c == 6) begin
        chk("t1_out_data", out_data, 64'hFEDCBA9876543210);
        chk("t1_out_id", W'(out_id), W'(2));
      end
      if (c == 7) chk("t1_busy", W'(busy), W'(0));
    end
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      req_valid = c < 8 ? 4'hF : 4'h0;
      @(negedge clk);
      chk("t2_grant", W'(req_ready), c < 8 ? W'(1 << (c % 4)) : W'(0));
      if (c >= 6 && c <= 13) begin
        chk("t2_out_valid", W'(out_valid), W'(1));
        chk("t2_out_id", W'(out_id), W'((c - 6) % 4));
      end
      nxt();
    end
    drain();
    do_reset();
    out_ready = 1'b0;
    req_valid = 4'hF;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk("t3_grant", W'(req_ready), c < 8 ? W'(1 << (c % 4)) : W'(0));
      if (c >= 13) chk("t3_count", W'(dut.fifo_count), W'(8));
      nxt();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_no_pop_credit", W'(req_ready), W'(0));
    nxt();
    @(negedge clk);
    chk("t3_resume", W'(req_ready), W'(4'b0001));
    nxt();
    drain();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req_valid = t4_v[c];
      @(negedge clk);
      chk("t4_grant", W'(req_ready), W'(t4_g[c]));
      nxt();
    end
    drain();
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      req_valid = c < 5 ? 4'hF : 4'h0;
      @(negedge clk);
      nxt();
    end
    reset = 1'b1;
    @(negedge clk);
    chk("t5_pre_count", W'(dut.fifo_count), W'(2));
    chk("t5_pre_inflight", W'(dut.inflight), W'(3));
    nxt();
    reset = 1'b0;
    req_valid = 4'hF;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_out_valid", W'(out_valid), W'(0));
    chk("t5_busy", W'(busy), W'(0));
    chk("t5_grant", W'(req_ready), W'(4'b0001));
    nxt();
    drain();
    do_reset();
    out_ready = 1'b0;
    req_valid = 4'hF;
    for (int c = 0; c < 14; c++) begin
      out_ready = c >= 12;
      @(negedge clk);
      if (c == 12) begin
        chk("t6_count_a", W'(dut.fifo_count), W'(7));
        chk("t6_write_pending", W'(dut.tag_v[LAT-1]), W'(1));
      end
      if (c == 13) chk("t6_count_b", W'(dut.fifo_count), W'(7));
      nxt();
    end
    drain();
    chk("no_overflow", W'(ovf), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
